spi_reg_slave: RTL
==================

SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

Interface
REQ-001: Parameter SYNC_STAGES, default 2: number of flip-flop synchronizer stages on sclk, copi and ncs (legal 2..3).
REQ-002: clk  input  1  system clock; all logic is synchronous to its rising edge.
REQ-003: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004: sclk  input  1  SPI serial clock from the controller, asynchronous to clk, mode 0 (CPOL=0, CPHA=0).
REQ-005: copi  input  1  SPI controller-out/peripheral-in data, asynchronous.
REQ-006: ncs  input  1  SPI chip select, active-low, asynchronous.
REQ-007: cipo  output  1  SPI peripheral-out data; readback only (see Configuration).
REQ-008: en_reg_out_7_0  output  8  register 0x00, output enables for outputs 7:0.
REQ-009: en_reg_out_15_8  output  8  register 0x01, output enables for outputs 15:8.
REQ-010: en_reg_pwm_7_0  output  8  register 0x02, PWM enables for outputs 7:0.
REQ-011: en_reg_pwm_15_8  output  8  register 0x03, PWM enables for outputs 15:8.
REQ-012: pwm_duty_cycle  output  8  register 0x04, shared PWM duty cycle (0x00 = 0%, 0xFF = 100%).

Function
REQ-013: sclk, copi and ncs shall each pass through SYNC_STAGES flops before any use; edges shall be detected on the synchronized signals only.
REQ-014: Frame format: 16 bits, MSB first, copi sampled on synchronized sclk rising edge while ncs low; bit15 = R/W (1 = write, 0 = read), bits14:8 = address, bits7:0 = data.
REQ-015: FSM states: IDLE, SHIFT, COMMIT.
REQ-016: IDLE -> SHIFT on synchronized ncs falling edge; bit counter and shift register cleared.
REQ-017: In SHIFT, each sclk rising edge shifts in one bit; the bit counter increments, saturating at 17 (overflow marker).
REQ-018: SHIFT -> COMMIT on synchronized ncs rising edge; COMMIT -> IDLE unconditionally after one clk.
REQ-019: In COMMIT, the addressed register is written only if count == 16, R/W = 1 and address <= 0x04; otherwise no register changes.
REQ-020: Frames of fewer or more than 16 bits shall be discarded silently.
REQ-021: Writes to addresses 0x05..0x7F shall be ignored.
REQ-022: Latency: a written register shall show the new value SYNC_STAGES+2 clk cycles after raw ncs rises; no other register shall change.
REQ-023: sclk edges while ncs is high shall be ignored.
REQ-024: If ncs rises and falls again before COMMIT completes, the new frame shall start in the cycle after COMMIT, and no bits shall be lost.
REQ-025: Supported timing: sclk period >= 8 clk periods; ncs high time >= 4 clk periods.
REQ-026: Register outputs shall be driven directly from flops (no combinational path from SPI inputs).

Reset
REQ-027: rst_n low shall force IDLE, clear the counter and shift register, set all five registers to 0x00 and set cipo to 0, independent of clk.
REQ-028: Reset asserted mid-frame shall abort the frame; after release, the block shall ignore that frame's remaining bits until the next ncs falling edge.

Configuration
REQ-029: Macro SPI_READBACK_EN: when defined, a frame with R/W = 0 shall, after the 8th bit, drive the addressed register MSB first on cipo; each bit shall update one clk after the synchronized sclk falling edge; unmapped addresses shall read 0x00.
REQ-030: Without SPI_READBACK_EN, cipo shall be tied to 0, read frames shall have no effect, and no readback logic shall be built.

Verification
REQ-031: Write 0x80,0xF0 (addr 0x00, data 0xF0) -> en_reg_out_7_0 = 0xF0 SYNC_STAGES+2 cycles after ncs rises; other registers remain 0x00.
REQ-032: Write addr 0x04 data 0x80, then addr 0x02 data 0x0F -> pwm_duty_cycle = 0x80 and en_reg_pwm_7_0 = 0x0F.
REQ-033: Write addr 0x05 data 0xAA, a 15-bit frame and a 17-bit frame targeting addr 0x01 -> all registers unchanged.
REQ-034: Assert rst_n low after 9 bits of a write to 0x03 with prior value 0x55 -> all registers = 0x00, and the following valid frame decodes correctly.
REQ-035: With SPI_READBACK_EN defined, write 0xC3 to addr 0x01, then read addr 0x01 -> cipo returns 1100_0011 on bits 8..15; without the macro, cipo stays 0.
REQ-036: Apply two back-to-back frames with minimum ncs high time -> both commit in order.

Source files
------------

// File: rtl/spi_reg_slave_if.sv
// SPI bus bundle for spi_reg_slave: mode-0 serial clock, data in/out and chip select.
interface spi_reg_slave_if;
    logic sclk;
    logic copi;
    logic ncs;
    logic cipo;

    modport master (
        output sclk,
        output copi,
        output ncs,
        input  cipo
    );

    modport slave (
        input  sclk,
        input  copi,
        input  ncs,
        output cipo
    );
endinterface

// File: rtl/spi_reg_slave.sv
// SPI mode-0 peripheral writing five 8-bit control registers from 16-bit frames.
// Optional readback on cipo is built only when SPI_READBACK_EN is defined.
module spi_reg_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_reg_slave_if.slave     spi,
    output logic [7:0]         en_reg_out_7_0,
    output logic [7:0]         en_reg_out_15_8,
    output logic [7:0]         en_reg_pwm_7_0,
    output logic [7:0]         en_reg_pwm_15_8,
    output logic [7:0]         pwm_duty_cycle
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] copi_sync_r;
    logic [SYNC_STAGES-1:0] ncs_sync_r;
    logic                   sclk_prev_r;
    logic                   ncs_prev_r;

    logic sclk_s;
    logic copi_s;
    logic ncs_s;
    logic sclk_rise_s;
    logic ncs_rise_s;
    logic ncs_fall_s;

    state_t      state_r;
    state_t      state_nxt;
    logic [4:0]  count_r;
    logic [4:0]  count_nxt;
    logic [15:0] shift_r;
    logic [15:0] shift_nxt;
    logic        pend_r;
    logic        pend_nxt;
    logic        write_en_s;

    logic [7:0] out_lo_r;
    logic [7:0] out_hi_r;
    logic [7:0] pwm_lo_r;
    logic [7:0] pwm_hi_r;
    logic [7:0] duty_r;

    // Input synchronizers. ncs resets low so a chip select already active at reset
    // release produces no falling edge and the interrupted frame is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            copi_sync_r <= {SYNC_STAGES{1'b0}};
            ncs_sync_r  <= {SYNC_STAGES{1'b0}};
            sclk_prev_r <= 1'b0;
            ncs_prev_r  <= 1'b0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi.sclk};
            copi_sync_r <= {copi_sync_r[SYNC_STAGES-2:0], spi.copi};
            ncs_sync_r  <= {ncs_sync_r[SYNC_STAGES-2:0], spi.ncs};
            sclk_prev_r <= sclk_sync_r[SYNC_STAGES-1];
            ncs_prev_r  <= ncs_sync_r[SYNC_STAGES-1];
        end
    end

    assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
    assign copi_s      = copi_sync_r[SYNC_STAGES-1];
    assign ncs_s       = ncs_sync_r[SYNC_STAGES-1];
    assign sclk_rise_s = sclk_s & ~sclk_prev_r;
    assign ncs_rise_s  = ncs_s & ~ncs_prev_r;
    assign ncs_fall_s  = ~ncs_s & ncs_prev_r;

    // Frame FSM state, bit counter, shift register and pending-frame flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            count_r <= 5'd0;
            shift_r <= 16'h0000;
            pend_r  <= 1'b0;
        end else begin
            state_r <= state_nxt;
            count_r <= count_nxt;
            shift_r <= shift_nxt;
            pend_r  <= pend_nxt;
        end
    end

    // Next-state logic. A frame whose select falls during COMMIT is remembered so it
    // starts from IDLE on the very next cycle without losing a coincident first bit.
    always_comb begin
        state_nxt = state_r;
        count_nxt = count_r;
        shift_nxt = shift_r;
        pend_nxt  = pend_r;
        case (state_r)
            ST_IDLE: begin
                if (ncs_fall_s || pend_r) begin
                    state_nxt = ST_SHIFT;
                    pend_nxt  = 1'b0;
                    if (sclk_rise_s && !ncs_s) begin
                        count_nxt = 5'd1;
                        shift_nxt = {15'h0000, copi_s};
                    end else begin
                        count_nxt = 5'd0;
                        shift_nxt = 16'h0000;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (ncs_rise_s) begin
                    state_nxt = ST_COMMIT;
                end else if (sclk_rise_s) begin
                    shift_nxt = {shift_r[14:0], copi_s};
                    if (count_r != 5'd17) begin
                        count_nxt = count_r + 5'd1;
                    end else begin
                        count_nxt = 5'd17;
                    end
                end else begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_COMMIT: begin
                state_nxt = ST_IDLE;
                if (ncs_fall_s) begin
                    pend_nxt = 1'b1;
                end else begin
                    pend_nxt = pend_r;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                count_nxt = 5'd0;
                shift_nxt = 16'h0000;
                pend_nxt  = 1'b0;
            end
        endcase
    end

    assign write_en_s = (state_r == ST_COMMIT) && (count_r == 5'd16) &&
                        shift_r[15] && (shift_r[14:8] <= 7'h04);

    // Register file; only a complete 16-bit write to a mapped address lands here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_lo_r <= 8'h00;
            out_hi_r <= 8'h00;
            pwm_lo_r <= 8'h00;
            pwm_hi_r <= 8'h00;
            duty_r   <= 8'h00;
        end else if (write_en_s) begin
            case (shift_r[10:8])
                3'd0:    out_lo_r <= shift_r[7:0];
                3'd1:    out_hi_r <= shift_r[7:0];
                3'd2:    pwm_lo_r <= shift_r[7:0];
                3'd3:    pwm_hi_r <= shift_r[7:0];
                3'd4:    duty_r   <= shift_r[7:0];
                default: duty_r   <= duty_r;
            endcase
        end else begin
            duty_r <= duty_r;
        end
    end

    assign en_reg_out_7_0  = out_lo_r;
    assign en_reg_out_15_8 = out_hi_r;
    assign en_reg_pwm_7_0  = pwm_lo_r;
    assign en_reg_pwm_15_8 = pwm_hi_r;
    assign pwm_duty_cycle  = duty_r;

`ifdef SPI_READBACK_EN
    logic       sclk_fall_s;
    logic [7:0] rd_data_s;
    logic [7:0] tx_r;
    logic       rd_act_r;
    logic       cipo_r;

    assign sclk_fall_s = ~sclk_s & sclk_prev_r;

    // Read mux addressed by the header byte as it completes; unmapped reads return zero.
    always_comb begin
        rd_data_s = 8'h00;
        case (shift_nxt[6:0])
            7'h00:   rd_data_s = out_lo_r;
            7'h01:   rd_data_s = out_hi_r;
            7'h02:   rd_data_s = pwm_lo_r;
            7'h03:   rd_data_s = pwm_hi_r;
            7'h04:   rd_data_s = duty_r;
            default: rd_data_s = 8'h00;
        endcase
    end

    // Readback shifter: loads on the 8th rising edge of a read frame, then presents
    // one data bit per falling edge so the controller samples it on the next rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_r     <= 8'h00;
            rd_act_r <= 1'b0;
            cipo_r   <= 1'b0;
        end else if (state_r != ST_SHIFT) begin
            tx_r     <= 8'h00;
            rd_act_r <= 1'b0;
            cipo_r   <= 1'b0;
        end else if (sclk_rise_s && !ncs_rise_s && (count_nxt == 5'd8) && !shift_nxt[7]) begin
            tx_r     <= rd_data_s;
            rd_act_r <= 1'b1;
        end else if (sclk_fall_s && rd_act_r && (count_r >= 5'd8) && (count_r <= 5'd15)) begin
            cipo_r <= tx_r[7];
            tx_r   <= {tx_r[6:0], 1'b0};
        end else begin
            cipo_r <= cipo_r;
        end
    end

    assign spi.cipo = cipo_r;
`else
    assign spi.cipo = 1'b0;
`endif

endmodule
